// File: rtl/conv_window_scan_ctrl_pkg.sv
// Shared definitions for the window-scan sequencer: default geometry,
// FSM state encoding and the {valid, last} tag carried down the delay line.
package conv_window_scan_ctrl_pkg;

  localparam int unsigned DEF_X_MAX      = 27;
  localparam int unsigned DEF_Y_MAX      = 27;
  localparam int unsigned DEF_STRIDE     = 1;
  localparam int unsigned DEF_NUM_MAPS   = 1;
  localparam int unsigned DEF_PIPE_DEPTH = 8;
  localparam int unsigned DEF_COORD_W    = 5;
  localparam int unsigned DEF_MAP_W      = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } rdy_tag_t;

endpackage

// File: rtl/conv_window_scan_ctrl_rdy_delay_line.sv
// rdy_delay_line: DEPTH-stage shift register that carries the issue tag
// alongside the multiply-adder tree so it exits in step with the tree output.
// Ports:
//   clock    - rising-edge clock
//   reset    - asynchronous active-low clear of every stage
//   shift_en - advance all stages by one when high, hold when low
//   din      - tag entering at the tail
//   dout     - tag at the head (oldest entry)
module rdy_delay_line #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else if (shift_en) begin
      stage[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/conv_window_scan_ctrl.sv
// conv_window_scan_ctrl: sequencer for the multiply-adder tree. Scans window
// origins x-major over NUM_MAPS feature maps with step STRIDE, pauses on input
// buffer underrun or downstream stall, and delays a {valid, last} tag so that
// pixel_rdy / frame_done line up with the tree output.
// Ports:
//   clock       - rising-edge clock
//   reset       - asynchronous active-low reset
//   buffer_rdy  - input window buffer holds valid data this cycle
//   stall       - downstream hold; freezes counters and delay line
//   x_coord     - current window x origin
//   y_coord     - current window y origin
//   map_sel     - current feature-map index
//   coord_valid - coordinates issued to the tree this cycle
//   pixel_rdy   - valid data at the end of the tree pipeline
//   frame_done  - pulse with the final pixel_rdy of a frame
//   busy        - sequencer is not idle
module conv_window_scan_ctrl
  import conv_window_scan_ctrl_pkg::*;
#(
  parameter int unsigned X_MAX      = DEF_X_MAX,
  parameter int unsigned Y_MAX      = DEF_Y_MAX,
  parameter int unsigned STRIDE     = DEF_STRIDE,
  parameter int unsigned NUM_MAPS   = DEF_NUM_MAPS,
  parameter int unsigned PIPE_DEPTH = DEF_PIPE_DEPTH,
  parameter int unsigned COORD_W    = DEF_COORD_W,
  parameter int unsigned MAP_W      = DEF_MAP_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               buffer_rdy,
  input  logic               stall,
  output logic [COORD_W-1:0] x_coord,
  output logic [COORD_W-1:0] y_coord,
  output logic [MAP_W-1:0]   map_sel,
  output logic               coord_valid,
  output logic               pixel_rdy,
  output logic               frame_done,
  output logic               busy
);

  localparam logic [COORD_W:0] STEP     = (COORD_W+1)'(STRIDE);
  localparam logic [COORD_W:0] X_LIMIT  = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W:0] Y_LIMIT  = (COORD_W+1)'(Y_MAX);
  localparam logic [MAP_W-1:0] MAP_LAST = MAP_W'(NUM_MAPS-1);

  scan_state_t state;

  // One extra bit on the sums so x+STRIDE past the coordinate width still
  // compares correctly against the limit.
  logic [COORD_W:0] x_sum;
  logic [COORD_W:0] y_sum;
  logic             x_wrap;
  logic             y_wrap;
  logic             map_wrap;
  logic             last_issue;

  rdy_tag_t                  tail_tag;
  rdy_tag_t                  head_tag;
  logic [$bits(rdy_tag_t)-1:0] head_bits;

  assign x_sum    = {1'b0, x_coord} + STEP;
  assign y_sum    = {1'b0, y_coord} + STEP;
  assign x_wrap   = (x_sum > X_LIMIT);
  assign y_wrap   = (y_sum > Y_LIMIT);
  assign map_wrap = (map_sel == MAP_LAST);

  assign coord_valid = (state == ST_SCAN) & buffer_rdy & ~stall;
  assign last_issue  = coord_valid & x_wrap & y_wrap & map_wrap;
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      x_coord <= '0;
      y_coord <= '0;
      map_sel <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (buffer_rdy) state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (coord_valid) begin
            x_coord <= x_wrap ? '0 : x_sum[COORD_W-1:0];
            if (x_wrap) begin
              y_coord <= y_wrap ? '0 : y_sum[COORD_W-1:0];
              if (y_wrap) map_sel <= map_wrap ? '0 : map_sel + MAP_W'(1);
            end
            // All three counters wrap on the final issue, so IDLE/DRAIN
            // always see them at zero.
            if (last_issue) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (frame_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tail_tag = '{valid: coord_valid, last: last_issue};

  rdy_delay_line #(
    .DEPTH (PIPE_DEPTH),
    .WIDTH ($bits(rdy_tag_t))
  ) u_rdy_delay_line (
    .clock    (clock),
    .reset    (reset),
    .shift_en (~stall),
    .din      (tail_tag),
    .dout     (head_bits)
  );

  assign head_tag   = rdy_tag_t'(head_bits);
  assign pixel_rdy  = head_tag.valid & ~stall;
  assign frame_done = head_tag.valid & head_tag.last & ~stall;

endmodule

// File: tb/tb_conv_window_scan_ctrl.sv
// Bench for conv_window_scan_ctrl. Three instances cover the default geometry
// (with pause, stall and mid-drain reset), a strided multi-map scan and a
// single-window frame. Each instance has a scoreboard: starting a frame pushes
// the expected coordinate sequence; every issue pushes a tag whose exit cycle
// is derived from the issue cycle, PIPE_DEPTH and intervening stall cycles.
module tb_conv_window_scan_ctrl;

  localparam int unsigned NDUT = 3;
  localparam int unsigned XM_T [NDUT] = '{27, 5, 0};
  localparam int unsigned YM_T [NDUT] = '{27, 5, 0};
  localparam int unsigned ST_T [NDUT] = '{1, 2, 1};
  localparam int unsigned NM_T [NDUT] = '{1, 3, 1};
  localparam int unsigned PD_T [NDUT] = '{8, 3, 4};

  typedef enum {M_IDLE, M_SCAN, M_DRAIN} mstate_t;
  typedef struct {int x; int y; int m; bit last;} coord_t;
  typedef struct {int t; int s; bit last;} tag_t;

  logic clock;
  logic rst_n [NDUT];
  logic brdy  [NDUT];
  logic stl   [NDUT];
  logic fd_a  [NDUT];
  logic bz_a  [NDUT];
  logic cv_a  [NDUT];
  int   xa    [NDUT];
  int   ya    [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input int g, input string tag,
                          input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL d%0d %s: got %0d expected %0d", g, tag, act, exp);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned XM = XM_T[g];
    localparam int unsigned YM = YM_T[g];
    localparam int unsigned ST = ST_T[g];
    localparam int unsigned NM = NM_T[g];
    localparam int unsigned PD = PD_T[g];
    localparam int unsigned MW = (NM > 1) ? $clog2(NM) : 1;
    localparam int TOTAL = NM * (XM / ST + 1) * (YM / ST + 1);

    logic [4:0]    x;
    logic [4:0]    y;
    logic [MW-1:0] m;
    logic          cv, pr, fd, bz;

    conv_window_scan_ctrl #(
      .X_MAX      (XM),
      .Y_MAX      (YM),
      .STRIDE     (ST),
      .NUM_MAPS   (NM),
      .PIPE_DEPTH (PD),
      .COORD_W    (5),
      .MAP_W      (MW)
    ) u_dut (
      .clock       (clock),
      .reset       (rst_n[g]),
      .buffer_rdy  (brdy[g]),
      .stall       (stl[g]),
      .x_coord     (x),
      .y_coord     (y),
      .map_sel     (m),
      .coord_valid (cv),
      .pixel_rdy   (pr),
      .frame_done  (fd),
      .busy        (bz)
    );

    assign fd_a[g] = fd;
    assign bz_a[g] = bz;
    assign cv_a[g] = cv;
    assign xa[g]   = int'(x);
    assign ya[g]   = int'(y);

    coord_t  eq[$];
    tag_t    pq[$];
    coord_t  c;
    mstate_t ms = M_IDLE;
    int      cyc = 0;
    int      stall_tot = 0;
    int      n_iss = 0;
    bit      exp_pix, exp_last, exp_cv;

    always @(negedge clock) begin
      if (!rst_n[g]) begin
        check_eq(g, "rst_x", x, 0);
        check_eq(g, "rst_y", y, 0);
        check_eq(g, "rst_map", m, 0);
        check_eq(g, "rst_coord_valid", cv, 0);
        check_eq(g, "rst_pixel_rdy", pr, 0);
        check_eq(g, "rst_frame_done", fd, 0);
        check_eq(g, "rst_busy", bz, 0);
        eq.delete();
        pq.delete();
        ms    = M_IDLE;
        n_iss = 0;
      end else begin
        exp_pix  = 1'b0;
        exp_last = 1'b0;
        if (!stl[g] && pq.size() > 0) begin
          if (cyc == pq[0].t + int'(PD) + (stall_tot - pq[0].s)) begin
            exp_pix  = 1'b1;
            exp_last = pq[0].last;
          end
        end
        check_eq(g, "pixel_rdy", pr, exp_pix);
        check_eq(g, "frame_done", fd, exp_pix & exp_last);
        if (exp_pix) void'(pq.pop_front());

        exp_cv = (ms == M_SCAN) && brdy[g] && !stl[g];
        check_eq(g, "coord_valid", cv, exp_cv);
        check_eq(g, "busy", bz, ms != M_IDLE);

        if (ms == M_SCAN && eq.size() > 0) begin
          check_eq(g, "x_coord", x, eq[0].x);
          check_eq(g, "y_coord", y, eq[0].y);
          check_eq(g, "map_sel", m, eq[0].m);
        end else begin
          check_eq(g, "x_idle", x, 0);
          check_eq(g, "y_idle", y, 0);
          check_eq(g, "map_idle", m, 0);
        end

        if (exp_cv && eq.size() > 0) begin
          c = eq.pop_front();
          pq.push_back('{cyc, stall_tot, c.last});
          n_iss++;
          if (c.last) ms = M_DRAIN;
        end else if (ms == M_IDLE && brdy[g]) begin
          for (int mm = 0; mm < int'(NM); mm++)
            for (int yy = 0; yy <= int'(YM); yy += int'(ST))
              for (int xx = 0; xx <= int'(XM); xx += int'(ST))
                eq.push_back('{xx, yy, mm,
                  (mm == int'(NM) - 1) && (yy + int'(ST) > int'(YM)) &&
                  (xx + int'(ST) > int'(XM))});
          ms    = M_SCAN;
          n_iss = 0;
        end

        if (exp_pix && exp_last) begin
          check_eq(g, "issues_per_frame", n_iss, TOTAL);
          ms = M_IDLE;
        end

        if (stl[g]) stall_tot++;
        cyc++;
      end
    end
  end

  task automatic wait_done(input int g, input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!fd_a[g] && n < budget);
    check_eq(g, "frame_done_seen", fd_a[g], 1);
  endtask

  task automatic wait_xy(input int g, input int xv, input int yv, input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(xa[g] == xv && ya[g] == yv && cv_a[g]) && n < budget);
    check_eq(g, "reached_x", xa[g], xv);
    check_eq(g, "reached_y", ya[g], yv);
  endtask

  task automatic wait_drain(input int g, input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(bz_a[g] && !cv_a[g]) && n < budget);
    check_eq(g, "drain_busy", bz_a[g], 1);
    check_eq(g, "drain_no_issue", cv_a[g], 0);
  endtask

  initial begin
    for (int i = 0; i < int'(NDUT); i++) begin
      rst_n[i] = 1'b0;
      brdy[i]  = 1'b0;
      stl[i]   = 1'b0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < int'(NDUT); i++) rst_n[i] = 1'b1;
    repeat (2) @(posedge clock);

    // Default geometry: pause before (5,3), stall mid-scan, run to completion.
    #1 brdy[0] = 1'b1;
    wait_xy(0, 4, 3, 400);
    @(posedge clock);
    #1 brdy[0] = 1'b0;
    repeat (3) @(posedge clock);
    #1 brdy[0] = 1'b1;
    wait_xy(0, 0, 10, 800);
    @(posedge clock);
    #1 stl[0] = 1'b1;
    repeat (4) @(posedge clock);
    #1 stl[0] = 1'b0;
    wait_done(0, 1200);

    // Second frame follows immediately; reset it mid-drain, then rescan.
    repeat (2) @(negedge clock);
    wait_drain(0, 1200);
    @(posedge clock);
    #3 rst_n[0] = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst_n[0] = 1'b1;
    wait_done(0, 1200);
    @(posedge clock);
    #1 brdy[0] = 1'b0;
    repeat (4) @(posedge clock);

    // Strided, three maps.
    #1 brdy[1] = 1'b1;
    wait_done(1, 200);
    @(posedge clock);
    #1 brdy[1] = 1'b0;
    repeat (6) @(posedge clock);

    // Single-window frame.
    #1 brdy[2] = 1'b1;
    wait_done(2, 50);
    @(posedge clock);
    #1 brdy[2] = 1'b0;
    repeat (6) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
